// File: rtl/execute_stage_pkg.sv
// Execute stage shared types: DE/EM/ED bundles, alu_op bit indices,
// divider defaults and a conditional-negate helper.
package execute_stage_pkg;

  localparam int ALU_OP_W = 19;

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_SLT   = 2;
  localparam int OP_SLTU  = 3;
  localparam int OP_AND   = 4;
  localparam int OP_NOR   = 5;
  localparam int OP_OR    = 6;
  localparam int OP_XOR   = 7;
  localparam int OP_SLL   = 8;
  localparam int OP_SRL   = 9;
  localparam int OP_SRA   = 10;
  localparam int OP_LUI   = 11;
  localparam int OP_MUL   = 12;
  localparam int OP_MULH  = 13;
  localparam int OP_MULHU = 14;
  localparam int OP_DIV   = 15;
  localparam int OP_MOD   = 16;
  localparam int OP_DIVU  = 17;
  localparam int OP_MODU  = 18;

  localparam int          DIV_ITERS_DEF = 32;
  localparam logic [31:0] DIVZ_QUO_DEF  = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0]         pc;
    logic [ALU_OP_W-1:0] alu_op;
    logic [31:0]         src1;
    logic [31:0]         src2;
    logic [31:0]         rkd_value;
    logic                gr_we;
    logic                mem_we;
    logic [4:0]          dest;
    logic                res_from_mem;
  } de_bus_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic        res_from_mem;
    logic [31:0] result;
  } em_bus_t;

  typedef struct packed {
    logic        stall;
    logic [4:0]  dest;
    logic [31:0] result;
  } ed_bus_t;

  function automatic logic [31:0] cond_neg(
    input logic        c,
    input logic [31:0] x
  );
    return c ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Execute stage boundary: DE in, EM out, ED forward, data SRAM request.
// master = surrounding pipeline/bench side, slave = execute_stage.
interface execute_stage_if;
  import execute_stage_pkg::*;

  logic        DE_valid;
  de_bus_t     DE_BUS;
  logic        M_allowin;
  logic        E_allowin;
  logic        EM_valid;
  em_bus_t     EM_BUS;
  ed_bus_t     ED_for_BUS;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;

  modport master (
    output DE_valid, DE_BUS, M_allowin,
    input  E_allowin, EM_valid, EM_BUS, ED_for_BUS,
    input  data_sram_en, data_sram_we,
    input  data_sram_addr, data_sram_wdata
  );

  modport slave (
    input  DE_valid, DE_BUS, M_allowin,
    output E_allowin, EM_valid, EM_BUS, ED_for_BUS,
    output data_sram_en, data_sram_we,
    output data_sram_addr, data_sram_wdata
  );

endinterface

// File: rtl/execute_stage_div_radix2.sv
// Iterative restoring divider, one quotient bit per cycle on magnitudes.
// Ports: start/ack/is_signed/dividend/divisor in; busy/done/quo/rem out.
module execute_stage_div_radix2
  import execute_stage_pkg::*;
#(
  parameter int          ITERS    = 32,
  parameter logic [31:0] DIVZ_QUO = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ack,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  localparam int CW = $clog2(ITERS + 1);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  logic [CW-1:0] cnt;
  logic [31:0]   pr;
  logic [31:0]   qr;
  logic [31:0]   dv;
  logic [31:0]   dvd;
  logic          neg_q;
  logic          neg_r;
  logic          divz;
  logic [32:0]   r_sh;
  logic [32:0]   diff;
  logic          take;
  logic [31:0]   pr_n;
  logic [31:0]   qr_n;

  // qr shifts dividend bits out the top while quotient bits enter below
  assign r_sh = {pr, qr[31]};
  assign diff = r_sh - {1'b0, dv};
  assign take = ~diff[32];
  assign pr_n = take ? diff[31:0] : r_sh[31:0];
  assign qr_n = {qr[30:0], take};

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      pr    <= '0;
      qr    <= '0;
      dv    <= '0;
      dvd   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      divz  <= 1'b0;
      quo   <= '0;
      rem   <= '0;
    end else begin
      if (start) begin
        busy  <= 1'b1;
        cnt   <= '0;
        pr    <= '0;
        qr    <= cond_neg(is_signed & dividend[31], dividend);
        dv    <= cond_neg(is_signed & divisor[31], divisor);
        dvd   <= dividend;
        neg_q <= is_signed & (dividend[31] ^ divisor[31]);
        neg_r <= is_signed & dividend[31];
        divz  <= (divisor == '0);
      end else if (busy) begin
        pr  <= pr_n;
        qr  <= qr_n;
        cnt <= cnt + CW'(1);
        if (cnt == LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
          // sign fix-up folded into the last step
          quo  <= divz ? DIVZ_QUO
                       : cond_neg(neg_q, qr_n);
          rem  <= divz ? dvd
                       : cond_neg(neg_r, pr_n);
        end
      end
      if (done & ack) done <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU/mul inline, div/mod via radix-2 divider, ld/st request.
// Ports: clk, rst (sync, high), bus (execute_stage_if.slave).
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int          DIV_ITERS = DIV_ITERS_DEF,
  parameter logic [31:0] DIVZ_QUO  = DIVZ_QUO_DEF
) (
  input logic             clk,
  input logic             rst,
  execute_stage_if.slave  bus
);

  logic                e_valid;
  de_bus_t             de_r;
  logic [ALU_OP_W-1:0] op;
  logic [31:0]         a;
  logic [31:0]         b;
  logic [4:0]          sh;
  logic                is_div;
  logic                ready_go;
  logic                em_fire;
  logic                div_start;
  logic                div_ack;
  logic                div_signed;
  logic                div_busy;
  logic                div_done;
  logic [31:0]         div_quo;
  logic [31:0]         div_rem;
  logic [31:0]         div_res;
  logic [31:0]         add_res;
  logic [31:0]         sub_res;
  logic [31:0]         sra_res;
  logic [63:0]         mul_u;
  logic [31:0]         mulh_s;
  logic [31:0]         alu_res;
  logic [31:0]         result;

  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid <= 1'b0;
      de_r    <= '0;
    end else if (bus.E_allowin) begin
      e_valid <= bus.DE_valid;
      if (bus.DE_valid) de_r <= bus.DE_BUS;
    end
  end

  assign op = de_r.alu_op;
  assign a  = de_r.src1;
  assign b  = de_r.src2;
  assign sh = de_r.src2[4:0];

  assign is_div = op[OP_DIV] | op[OP_MOD]
                | op[OP_DIVU] | op[OP_MODU];
  assign div_signed = op[OP_DIV] | op[OP_MOD];

  assign ready_go = ~is_div | div_done;
  assign em_fire  = bus.EM_valid & bus.M_allowin;

  assign bus.E_allowin = ~e_valid
                       | (ready_go & bus.M_allowin);
  assign bus.EM_valid  = e_valid & ready_go;

  assign div_start = e_valid & is_div
                   & ~div_busy & ~div_done;
  assign div_ack   = em_fire & is_div;

  execute_stage_div_radix2 #(
    .ITERS    (DIV_ITERS),
    .DIVZ_QUO (DIVZ_QUO)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .ack       (div_ack),
    .is_signed (div_signed),
    .dividend  (a),
    .divisor   (b),
    .busy      (div_busy),
    .done      (div_done),
    .quo       (div_quo),
    .rem       (div_rem)
  );

  assign add_res = a + b;
  assign sub_res = a - b;
  assign sra_res = $signed(a) >>> sh;

  // one unsigned multiplier; signed high word by two's-complement correction
  assign mul_u  = {32'd0, a} * {32'd0, b};
  assign mulh_s = mul_u[63:32]
                - (a[31] ? b : 32'd0)
                - (b[31] ? a : 32'd0);

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      op[OP_ADD]:   alu_res = add_res;
      op[OP_SUB]:   alu_res = sub_res;
      op[OP_SLT]:   alu_res = {31'd0, $signed(a) < $signed(b)};
      op[OP_SLTU]:  alu_res = {31'd0, a < b};
      op[OP_AND]:   alu_res = a & b;
      op[OP_NOR]:   alu_res = ~(a | b);
      op[OP_OR]:    alu_res = a | b;
      op[OP_XOR]:   alu_res = a ^ b;
      op[OP_SLL]:   alu_res = a << sh;
      op[OP_SRL]:   alu_res = a >> sh;
      op[OP_SRA]:   alu_res = sra_res;
      op[OP_LUI]:   alu_res = b;
      op[OP_MUL]:   alu_res = mul_u[31:0];
      op[OP_MULH]:  alu_res = mulh_s;
      op[OP_MULHU]: alu_res = mul_u[63:32];
      default:      alu_res = '0;
    endcase
  end

  assign div_res = (op[OP_DIV] | op[OP_DIVU])
                 ? div_quo : div_rem;
  assign result  = is_div ? div_res : alu_res;

  always_comb begin
    bus.EM_BUS.pc           = de_r.pc;
    bus.EM_BUS.gr_we        = de_r.gr_we;
    bus.EM_BUS.dest         = de_r.dest;
    bus.EM_BUS.res_from_mem = de_r.res_from_mem;
    bus.EM_BUS.result       = result;
  end

  always_comb begin
    bus.ED_for_BUS.stall  = e_valid
                          & (de_r.res_from_mem
                          | (is_div & ~div_done));
    bus.ED_for_BUS.dest   = (e_valid & de_r.gr_we)
                          ? de_r.dest : 5'd0;
    bus.ED_for_BUS.result = result;
  end

  // request only on the fire cycle so M back-pressure never repeats it
  assign bus.data_sram_en    = em_fire
                             & (de_r.res_from_mem | de_r.mem_we);
  assign bus.data_sram_we    = {4{bus.data_sram_en & de_r.mem_we}};
  assign bus.data_sram_addr  = add_res;
  assign bus.data_sram_wdata = de_r.rkd_value;

endmodule
